// File: rtl/reg_fetch_stage.sv
// Register-fetch stage between decode and execute: register file with write bypass,
// immediate extension and one output register with valid/ready handshake and flush.
module reg_fetch_stage #(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int DBITS               = 32,
  parameter int IMM_BITS            = 16,
  parameter int ZERO_REG            = 1
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic                           flush,
  input  logic                           inValid,
  output logic                           inReady,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rs1,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rs2,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] rd,
  input  logic [IMM_BITS-1:0]            imm,
  input  logic [1:0]                     immMode,
  input  logic                           wrtEn,
  input  logic [REG_INDEX_BIT_WIDTH-1:0] wrtIdx,
  input  logic [DBITS-1:0]               wrtData,
  output logic                           outValid,
  input  logic                           outReady,
  output logic [DBITS-1:0]               outReg1,
  output logic [DBITS-1:0]               outReg2,
  output logic [DBITS-1:0]               imm32,
  output logic [REG_INDEX_BIT_WIDTH-1:0] outRd,
  output logic [REG_INDEX_BIT_WIDTH-1:0] outRs1,
  output logic [REG_INDEX_BIT_WIDTH-1:0] outRs2
);

  localparam int NUM_REGS = 2 ** REG_INDEX_BIT_WIDTH;

  logic [DBITS-1:0] regs [NUM_REGS];

  logic             wrtEff;
  logic             capture;
  logic [DBITS-1:0] rdData1;
  logic [DBITS-1:0] rdData2;
  logic [DBITS-1:0] immExt;

  // Writes to the hardwired zero register are dropped everywhere, including the bypasses.
  assign wrtEff  = wrtEn && !((ZERO_REG == 1) && (wrtIdx == '0));
  assign inReady = !outValid || outReady;
  assign capture = inValid && inReady && !flush;

  always_comb begin
    rdData1 = regs[rs1];
    if (wrtEff && (wrtIdx == rs1)) rdData1 = wrtData;
    if ((ZERO_REG == 1) && (rs1 == '0)) rdData1 = '0;

    rdData2 = regs[rs2];
    if (wrtEff && (wrtIdx == rs2)) rdData2 = wrtData;
    if ((ZERO_REG == 1) && (rs2 == '0)) rdData2 = '0;
  end

  always_comb begin
    case (immMode)
      2'd1:    immExt = {{(DBITS-IMM_BITS){1'b0}}, imm};
      2'd2:    immExt = {imm, {(DBITS-IMM_BITS){1'b0}}};
      default: immExt = {{(DBITS-IMM_BITS){imm[IMM_BITS-1]}}, imm};
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      outValid <= 1'b0;
      outReg1  <= '0;
      outReg2  <= '0;
      imm32    <= '0;
      outRd    <= '0;
      outRs1   <= '0;
      outRs2   <= '0;
    end else begin
      if (wrtEff) regs[wrtIdx] <= wrtData;

      if (flush) begin
        outValid <= 1'b0;
      end else if (capture) begin
        outValid <= 1'b1;
        outReg1  <= rdData1;
        outReg2  <= rdData2;
        imm32    <= immExt;
        outRd    <= rd;
        outRs1   <= rs1;
        outRs2   <= rs2;
      end else if (outValid && outReady) begin
        outValid <= 1'b0;
      end else if (outValid) begin
        // Stalled bundle picks up late writebacks so its operands never go stale.
        if (wrtEff && (wrtIdx == outRs1)) outReg1 <= wrtData;
        if (wrtEff && (wrtIdx == outRs2)) outReg2 <= wrtData;
      end
    end
  end

endmodule

// File: doc/reg_fetch_stage.md
Name: reg_fetch_stage

Overview:
- Parametrised, pipelined register-fetch stage: internal register file, write-to-read bypass, selectable immediate extension, and one output pipeline register with valid/ready handshake and flush.
- Sits between decode and execute.
- Replaces the purely combinational fetch path so the stage can stall and be flushed without losing writeback data.

Parameters:
- REG_INDEX_BIT_WIDTH, 4, register index width; NUM_REGS = 2**REG_INDEX_BIT_WIDTH.
- DBITS, 32, data width.
- IMM_BITS, 16, raw immediate width; must be < DBITS.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero.

Ports:
- clk  in  1  clock, all state on rising edge.
- res  in  1  synchronous active-high reset.
- flush  in  1  drop the held output and the current input.
- inValid  in  1  decode presents an instruction.
- inReady  out  1  stage accepts the instruction this cycle.
- rs1, rs2, rd  in  REG_INDEX_BIT_WIDTH  source and destination indices.
- imm  in  IMM_BITS  raw immediate.
- immMode  in  2  0 sign-extend, 1 zero-extend, 2 upper (imm in top IMM_BITS, low bits 0), 3 treated as 0.
- wrtEn  in  1  writeback enable.
- wrtIdx  in  REG_INDEX_BIT_WIDTH  writeback index.
- wrtData  in  DBITS  writeback data.
- outValid  out  1  output bundle valid.
- outReady  in  1  execute consumes the bundle.
- outReg1, outReg2  out  DBITS  operand values.
- imm32  out  DBITS  extended immediate.
- outRd, outRs1, outRs2  out  REG_INDEX_BIT_WIDTH  forwarded indices.

Behaviour:
- Reset (res=1 at edge):
  - all registers := 0; outValid := 0; all output data and index registers := 0.
  - Reset overrides wrtEn, flush and capture.
- Register file write:
  - on edge when wrtEn=1, reg[wrtIdx] := wrtData.
  - If ZERO_REG=1 and wrtIdx=0, the write is ignored.
  - Writes occur regardless of stall or flush.
- Read path (combinational, feeds capture):
  - operand = reg[rsN], except:
    - if wrtEn=1 and wrtIdx=rsN (and not the zero register), operand = wrtData (same-cycle bypass).
    - If ZERO_REG=1 and rsN=0, operand = 0 always.
- inReady = !outValid | outReady, combinational. It is independent of inValid.
- Capture:
  - on edge with inValid & inReady & !flush, load operands, extended immediate, and rd/rs1/rs2 into the output registers; outValid := 1.
  - Latency 1 cycle, input to outValid.
- Drain: on edge with outValid & outReady and no capture, outValid := 0. Data registers keep their last values.
- Hold bypass (stall case):
  - while outValid=1 and outReady=0, a write with wrtIdx=outRs1 updates outReg1 := wrtData at that edge; same for outRs2/outReg2.
  - Zero-register rule applies.
  - Guarantees no lost writeback during stall.
- Flush: on edge with flush=1, outValid := 0 and no capture, even if inValid & inReady. Register file writes still happen.
- Back-to-back:
  - with outReady held 1 and inValid held 1, one bundle is produced per cycle.
  - Capture and drain on the same edge leave outValid=1 with the new bundle.
- Immediate, mode 2: imm32 = {imm, (DBITS-IMM_BITS) zeros}.
- Reads of an index never written since reset return 0.

Test Plan:
- Reset then fetch rs1=3, rs2=5, imm=16'hFFFF, mode 0, no writes.
  - Required: after 1 cycle outValid=1, outReg1=0, outReg2=0, imm32=32'hFFFFFFFF.
  - Mode 1 gives 32'h0000FFFF; mode 2 with imm=16'h1234 gives 32'h12340000.
- Same-cycle bypass: wrtEn=1, wrtIdx=3, wrtData=32'hDEADBEEF while fetching rs1=3.
  - Required: outReg1=32'hDEADBEEF next cycle.
  - A fetch two cycles later still reads 32'hDEADBEEF.
- Zero register: write 32'h55 to index 0, then fetch rs1=0, also with a concurrent wrtIdx=0 write.
  - Required: outReg1=0 both times.
- Stall with hold bypass: capture bundle with rs2=7 (value 1) while outReady=0; two cycles later write reg7=32'hA5.
  - Required: inReady=0 during stall, outReg2=32'hA5 while held, bundle unchanged otherwise.
  - With outReady=1, the bundle drains and the next input is accepted the same edge.
- Flush: outValid=1 with inValid=1 and flush=1 on the same edge, plus wrtEn to reg2=9.
  - Required: outValid=0 next cycle, input not captured, reg2 reads 9 afterwards.
- Reset mid-stream: res=1 while outValid=1 and wrtEn=1.
  - Required: next cycle outValid=0, all outputs 0, the written register reads 0.
